// File: rtl/mdom_multichan_trigger.sv
// N-channel trigger front end: delays ADC/discr streams and makes per-channel trigger, source and ToT flags.
// Latency: 2 cycles sample->trig and stream outputs (3-4 from the ext_run pin); no backpressure, every cycle is decided.
module mdom_multichan_trigger #(
    parameter int P_N_CH          = 4,
    parameter int P_ADC_WIDTH     = 12,
    parameter int P_DISCR_WIDTH   = 8,
    parameter int P_HOLDOFF_WIDTH = 8,
    parameter int P_WIN_WIDTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [P_N_CH*P_ADC_WIDTH-1:0]      adc_stream_in,
    output logic [P_N_CH*P_ADC_WIDTH-1:0]      adc_stream_out,
    input  logic [P_N_CH*P_DISCR_WIDTH-1:0]    discr_stream_in,
    output logic [P_N_CH*P_DISCR_WIDTH-1:0]    discr_stream_out,
    input  logic [P_N_CH*P_ADC_WIDTH-1:0]      thr,
    input  logic                               gt,
    input  logic                               et,
    input  logic                               lt,
    input  logic [P_N_CH-1:0]                  thresh_trig_en,
    input  logic [P_N_CH-1:0]                  discr_trig_en,
    input  logic                               discr_trig_pol,
    input  logic                               run,
    input  logic                               ext_run,
    input  logic                               ext_trig_en,
    input  logic                               coinc_mode,
    input  logic [7:0]                         coinc_mult,
    input  logic [P_WIN_WIDTH-1:0]             coinc_win,
    input  logic [P_HOLDOFF_WIDTH-1:0]         holdoff,
    output logic [P_N_CH-1:0]                  trig,
    output logic [2*P_N_CH-1:0]                trig_src,
    output logic [P_N_CH-1:0]                  thresh_tot,
    output logic [P_N_CH-1:0]                  discr_tot
);
    localparam int AW = P_ADC_WIDTH;
    localparam int DW = P_DISCR_WIDTH;

    logic [P_N_CH-1:0]    cond_raw, dhit_raw;
    logic [P_N_CH-1:0]    cond_s1, cond_s2, dhit_s1, dhit_s2;
    logic [P_N_CH-1:0]    ttot_s1, dtot_s1;
    logic [P_N_CH*AW-1:0] adc_d1;
    logic [P_N_CH*DW-1:0] discr_d1;
    logic                 run_s1, run_s2, ext_m, ext_s, ext_q, coinc_mode_q;
    logic [P_N_CH-1:0][P_HOLDOFF_WIDTH-1:0] ho;
    logic [P_N_CH-1:0][P_WIN_WIDTH-1:0]     win;
    logic [P_N_CH-1:0]    win_th;
    logic [P_N_CH-1:0]    th_evt, di_evt, ready, win_nz, new_evt, hit, trig_nxt;
    logic [2*P_N_CH-1:0]  src_nxt;
    logic                 sw_evt, ext_evt, fire;
    logic [8:0]           hit_cnt, m_eff;

    for (genvar g = 0; g < P_N_CH; g++) begin : g_ch
        logic [AW-1:0] smp, lvl;
        assign smp         = adc_stream_in[g*AW +: AW];
        assign lvl         = thr[g*AW +: AW];
        assign cond_raw[g] = (gt & (smp > lvl)) | (et & (smp == lvl)) | (lt & (smp < lvl));
        assign dhit_raw[g] = |(discr_stream_in[g*DW +: DW] ^ {DW{~discr_trig_pol}});
        assign ready[g]    = (ho[g] == '0);
        assign win_nz[g]   = (win[g] != '0);
    end

    // Edge-history flops reset to 1 so a level already high at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_d1           <= '0;
            adc_stream_out   <= '0;
            discr_d1         <= '0;
            discr_stream_out <= '0;
            cond_s1          <= '1;
            cond_s2          <= '1;
            dhit_s1          <= '1;
            dhit_s2          <= '1;
            ttot_s1          <= '0;
            thresh_tot       <= '0;
            dtot_s1          <= '0;
            discr_tot        <= '0;
            run_s1           <= 1'b1;
            run_s2           <= 1'b1;
            ext_m            <= 1'b1;
            ext_s            <= 1'b1;
            ext_q            <= 1'b1;
        end else begin
            adc_d1           <= adc_stream_in;
            adc_stream_out   <= adc_d1;
            discr_d1         <= discr_stream_in;
            discr_stream_out <= discr_d1;
            cond_s1          <= cond_raw;
            cond_s2          <= cond_s1;
            dhit_s1          <= dhit_raw;
            dhit_s2          <= dhit_s1;
            ttot_s1          <= cond_raw;
            thresh_tot       <= ttot_s1;
            dtot_s1          <= dhit_raw;
            discr_tot        <= dtot_s1;
            run_s1           <= run;
            run_s2           <= run_s1;
            ext_m            <= ext_run;
            ext_s            <= ext_m;
            ext_q            <= ext_s;
        end
    end

    assign th_evt  = cond_s1 & ~cond_s2 & thresh_trig_en;
    assign di_evt  = dhit_s1 & ~dhit_s2 & discr_trig_en;
    assign sw_evt  = run_s1 & ~run_s2;
    assign ext_evt = ext_s & ~ext_q & ext_trig_en;
    assign new_evt = (th_evt | di_evt) & ready;
    assign hit     = ready & (new_evt | win_nz);
    assign m_eff   = (coinc_mult == 8'd0) ? 9'd1 : {1'b0, coinc_mult};

    always_comb begin
        hit_cnt  = '0;
        trig_nxt = '0;
        src_nxt  = '0;
        for (int i = 0; i < P_N_CH; i++) hit_cnt = hit_cnt + 9'(hit[i]);
        fire = coinc_mode & (|new_evt) & (hit_cnt >= m_eff);
        for (int i = 0; i < P_N_CH; i++) begin
            if (ready[i]) begin
                if (sw_evt) begin
                    trig_nxt[i]        = 1'b1;
                    src_nxt[2*i +: 2]  = 2'd2;
                end else if (ext_evt) begin
                    trig_nxt[i]        = 1'b1;
                    src_nxt[2*i +: 2]  = 2'd1;
                end else if (!coinc_mode) begin
                    trig_nxt[i]        = th_evt[i] | di_evt[i];
                    src_nxt[2*i +: 2]  = th_evt[i] ? 2'd0 : (di_evt[i] ? 2'd3 : 2'd0);
                end else if (fire && hit[i]) begin
                    // A channel counts as threshold-sourced if this cycle or its open window came from a threshold edge.
                    trig_nxt[i]        = 1'b1;
                    src_nxt[2*i +: 2]  = (th_evt[i] | (win_nz[i] & win_th[i])) ? 2'd0 : 2'd3;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ho           <= '0;
            win          <= '0;
            win_th       <= '0;
            coinc_mode_q <= 1'b0;
            trig         <= '0;
            trig_src     <= '0;
        end else begin
            coinc_mode_q <= coinc_mode;
            trig         <= trig_nxt;
            trig_src     <= src_nxt;
            for (int i = 0; i < P_N_CH; i++) begin
                if (trig_nxt[i])
                    ho[i] <= holdoff;
                else if (!ready[i])
                    ho[i] <= ho[i] - P_HOLDOFF_WIDTH'(1);
                if (fire || (coinc_mode != coinc_mode_q)) begin
                    win[i]    <= '0;
                    win_th[i] <= 1'b0;
                end else if (coinc_mode && new_evt[i]) begin
                    win[i]    <= coinc_win;
                    win_th[i] <= th_evt[i] | (win_nz[i] & win_th[i]);
                end else if (win_nz[i]) begin
                    win[i]    <= win[i] - P_WIN_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mdom_multichan_trigger.sv
// Bench for mdom_multichan_trigger: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_mdom_multichan_trigger;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int HW = 8;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] adc_stream_in, adc_stream_out, thr;
    logic [N*DW-1:0] discr_stream_in, discr_stream_out;
    logic            gt, et, lt, discr_trig_pol, run, ext_run, ext_trig_en, coinc_mode;
    logic [N-1:0]    thresh_trig_en, discr_trig_en, trig, thresh_tot, discr_tot;
    logic [7:0]      coinc_mult;
    logic [WW-1:0]   coinc_win;
    logic [HW-1:0]   holdoff;
    logic [2*N-1:0]  trig_src;

    mdom_multichan_trigger #(.P_N_CH(N), .P_ADC_WIDTH(AW), .P_DISCR_WIDTH(DW),
                             .P_HOLDOFF_WIDTH(HW), .P_WIN_WIDTH(WW)) dut (
        .clk(clk), .rst(rst),
        .adc_stream_in(adc_stream_in), .adc_stream_out(adc_stream_out),
        .discr_stream_in(discr_stream_in), .discr_stream_out(discr_stream_out),
        .thr(thr), .gt(gt), .et(et), .lt(lt),
        .thresh_trig_en(thresh_trig_en), .discr_trig_en(discr_trig_en),
        .discr_trig_pol(discr_trig_pol), .run(run), .ext_run(ext_run),
        .ext_trig_en(ext_trig_en), .coinc_mode(coinc_mode), .coinc_mult(coinc_mult),
        .coinc_win(coinc_win), .holdoff(holdoff), .trig(trig), .trig_src(trig_src),
        .thresh_tot(thresh_tot), .discr_tot(discr_tot)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: inputs captured per edge, indexed by edge count since reset release.
    typedef struct packed {
        logic [N*AW-1:0] adc;
        logic [N*DW-1:0] dw;
        logic [N-1:0]    cond;
        logic [N-1:0]    dhit;
        logic            run;
        logic            ext;
    } cap_t;

    cap_t            cap [8];
    int              sr;
    int              ready_from [N];
    int              win_until [N];
    bit              win_thr [N];
    logic            mode_prev;
    logic [N-1:0]    e_trig, e_tt, e_dt;
    logic [2*N-1:0]  e_src;
    logic [N*AW-1:0] e_adc;
    logic [N*DW-1:0] e_dw;

    task automatic model_clear();
        sr = 0;
        mode_prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            ready_from[i] = 0;
            win_until[i]  = -1;
            win_thr[i]    = 1'b0;
        end
        e_trig = '0; e_src = '0; e_adc = '0; e_dw = '0; e_tt = '0; e_dt = '0;
    endtask

    function automatic logic [N-1:0] cond_now();
        logic [N-1:0] r;
        int s, t;
        for (int i = 0; i < N; i++) begin
            s = int'(adc_stream_in[i*AW +: AW]);
            t = int'(thr[i*AW +: AW]);
            r[i] = (gt && s > t) || (et && s == t) || (lt && s < t);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] dhit_now();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = discr_trig_pol ? (discr_stream_in[i*DW +: DW] != 8'h00)
                                  : (discr_stream_in[i*DW +: DW] != 8'hFF);
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] p1, p2, d1, d2, th, di, rdy, nw, hit;
        logic         sw, ex, fire;
        int           k, m;
        if (rst) begin
            model_clear();
            return;
        end
        sr++;
        k  = sr;
        p1 = (k >= 2) ? cap[(k-1)%8].cond : '1;
        p2 = (k >= 3) ? cap[(k-2)%8].cond : '1;
        d1 = (k >= 2) ? cap[(k-1)%8].dhit : '1;
        d2 = (k >= 3) ? cap[(k-2)%8].dhit : '1;
        sw = ((k >= 2) ? cap[(k-1)%8].run : 1'b1) & ~((k >= 3) ? cap[(k-2)%8].run : 1'b1);
        ex = ((k >= 3) ? cap[(k-2)%8].ext : 1'b1) & ~((k >= 4) ? cap[(k-3)%8].ext : 1'b1) & ext_trig_en;
        th = p1 & ~p2 & thresh_trig_en;
        di = d1 & ~d2 & discr_trig_en;
        for (int i = 0; i < N; i++) rdy[i] = (k >= ready_from[i]);
        nw = (th | di) & rdy;
        for (int i = 0; i < N; i++) hit[i] = rdy[i] && (nw[i] || k <= win_until[i]);
        m    = (coinc_mult == 0) ? 1 : int'(coinc_mult);
        fire = coinc_mode && (nw != 0) && ($countones(hit) >= m);
        e_trig = '0;
        e_src  = '0;
        for (int i = 0; i < N; i++) begin
            if (!rdy[i]) continue;
            if (sw) begin
                e_trig[i] = 1'b1; e_src[2*i +: 2] = 2'd2;
            end else if (ex) begin
                e_trig[i] = 1'b1; e_src[2*i +: 2] = 2'd1;
            end else if (!coinc_mode) begin
                if (th[i]) begin
                    e_trig[i] = 1'b1; e_src[2*i +: 2] = 2'd0;
                end else if (di[i]) begin
                    e_trig[i] = 1'b1; e_src[2*i +: 2] = 2'd3;
                end
            end else if (fire && hit[i]) begin
                e_trig[i] = 1'b1;
                e_src[2*i +: 2] = (th[i] || (k <= win_until[i] && win_thr[i])) ? 2'd0 : 2'd3;
            end
        end
        for (int i = 0; i < N; i++)
            if (e_trig[i]) ready_from[i] = k + 1 + int'(holdoff);
        if (coinc_mode != mode_prev || fire) begin
            for (int i = 0; i < N; i++) begin
                win_until[i] = -1;
                win_thr[i]   = 1'b0;
            end
        end else if (coinc_mode) begin
            for (int i = 0; i < N; i++)
                if (nw[i]) begin
                    win_thr[i]   = th[i] || (k <= win_until[i] && win_thr[i]);
                    win_until[i] = k + int'(coinc_win);
                end
        end
        mode_prev = coinc_mode;
        e_adc = (k >= 2) ? cap[(k-1)%8].adc  : '0;
        e_dw  = (k >= 2) ? cap[(k-1)%8].dw   : '0;
        e_tt  = (k >= 2) ? cap[(k-1)%8].cond : '0;
        e_dt  = (k >= 2) ? cap[(k-1)%8].dhit : '0;
        cap[k%8].adc  = adc_stream_in;
        cap[k%8].dw   = discr_stream_in;
        cap[k%8].cond = cond_now();
        cap[k%8].dhit = dhit_now();
        cap[k%8].run  = run;
        cap[k%8].ext  = ext_run;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("trig", trig, e_trig);
        check("trig_src", trig_src, e_src);
        check("adc_out", adc_stream_out, e_adc);
        check("discr_out", discr_stream_out, e_dw);
        check("thresh_tot", thresh_tot, e_tt);
        check("discr_tot", discr_tot, e_dt);
    endtask

    task automatic set_adc(input int ch, input int val);
        adc_stream_in[ch*AW +: AW] = AW'(val);
    endtask

    task automatic set_idle();
        adc_stream_in = '0; discr_stream_in = '0; discr_trig_pol = 1'b1;
        for (int i = 0; i < N; i++) thr[i*AW +: AW] = 12'd100;
        gt = 1'b1; et = 1'b0; lt = 1'b0;
        thresh_trig_en = '0; discr_trig_en = '0;
        run = 1'b0; ext_run = 1'b0; ext_trig_en = 1'b0;
        coinc_mode = 1'b0; coinc_mult = 8'd1; coinc_win = '0; holdoff = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ramp [5];
        int lat;
        logic [11:0] mask;
        rst = 1'b1;
        set_idle();
        model_clear();
        do_reset();
        check("reset_trig", trig, 4'b0000);

        // Threshold ramp on ch1
        ramp = '{98, 99, 100, 101, 102};
        thresh_trig_en = 4'b0010;
        mask = '0;
        for (int j = 0; j < 7; j++) begin
            set_adc(1, (j < 5) ? ramp[j] : 102);
            step();
            mask[j] = trig[1];
            if (j == 4) begin
                check("ramp_src", trig_src[3:2], 2'd0);
                check("ramp_adc", adc_stream_out[AW +: AW], 12'd101);
                check("ramp_tot", thresh_tot[1], 1'b1);
            end
        end
        check("ramp_mask", mask[6:0], 7'b0010000);

        // Holdoff drops the middle crossing
        set_idle(); do_reset();
        thresh_trig_en = 4'b0001; holdoff = 8'd5;
        repeat (2) step();
        mask = '0;
        for (int j = 0; j < 12; j++) begin
            set_adc(0, (j == 0 || j == 3 || j == 7) ? 200 : 0);
            step();
            mask[j] = trig[0];
        end
        check("holdoff_mask", mask, 12'h102);

        // 2-of-4 coincidence with window 3
        set_idle(); do_reset();
        coinc_mode = 1'b1; coinc_mult = 8'd2; coinc_win = 4'd3; thresh_trig_en = 4'b0101;
        repeat (2) step();
        for (int j = 0; j < 9; j++) begin
            set_adc(0, (j == 0) ? 200 : 0);
            set_adc(2, (j == 2 || j == 5) ? 200 : 0);
            step();
            check("coinc_trig", trig, (j == 3) ? 4'b0101 : 4'b0000);
            if (j == 3) check("coinc_src", trig_src, 8'h00);
        end

        // Software trigger wins over a simultaneous ch3 threshold edge
        set_idle(); do_reset();
        thresh_trig_en = 4'b1000;
        repeat (2) step();
        set_adc(3, 200); run = 1'b1;
        step(); step();
        check("sw_trig", trig, 4'b1111);
        check("sw_src", trig_src, 8'hAA);
        run = 1'b0; step();

        // Level high through reset release, then an external pulse
        set_idle(); thresh_trig_en = 4'b0001; set_adc(0, 200);
        do_reset();
        for (int j = 0; j < 4; j++) begin
            step();
            check("rst_level_notrig", trig, 4'b0000);
        end
        ext_trig_en = 1'b1; ext_run = 1'b1;
        lat = -1;
        for (int j = 1; j <= 8 && lat < 0; j++) begin
            step();
            if (trig == 4'b1111) lat = j;
        end
        check("ext_src", trig_src, 8'h55);
        check("ext_lat_in_3_4", (lat >= 3 && lat <= 4), 1'b1);
        ext_run = 1'b0; repeat (2) step();

        // Reset in the middle of a long holdoff
        set_idle(); do_reset();
        thresh_trig_en = 4'b0001; holdoff = 8'd200;
        repeat (2) step();
        set_adc(0, 200);
        step(); step();
        check("ho_first_trig", trig, 4'b0001);
        repeat (3) step();
        check("pre_rst_tot", thresh_tot[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_trig", trig, 4'b0000);
        check("async_rst_tot", thresh_tot, 4'b0000);
        model_clear();
        set_adc(0, 0);
        step();
        rst = 1'b0;
        repeat (2) step();
        set_adc(0, 200);
        step(); step();
        check("post_rst_trig", trig, 4'b0001);

        // Randomized traffic against the model
        set_idle(); do_reset();
        for (int s = 0; s < 6; s++) begin
            discr_trig_pol = 1'($urandom_range(0, 1));
            {gt, et, lt}   = 3'($urandom_range(1, 7));
            thresh_trig_en = 4'($urandom);
            discr_trig_en  = 4'($urandom);
            holdoff        = 8'($urandom_range(0, 6));
            coinc_mode     = 1'($urandom_range(0, 1));
            coinc_mult     = 8'($urandom_range(0, 5));
            coinc_win      = 4'($urandom_range(0, 5));
            ext_trig_en    = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) thr[i*AW +: AW] = 12'($urandom_range(95, 105));
            repeat (250) begin
                for (int i = 0; i < N; i++) begin
                    set_adc(i, int'($urandom_range(90, 110)));
                    discr_stream_in[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                : (discr_trig_pol ? 8'h00 : 8'hFF);
                end
                if ($urandom_range(0, 9) == 0)  run = ~run;
                if ($urandom_range(0, 11) == 0) ext_run = ~ext_run;
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
